// File: rtl/bcd_pkg.sv
// Shared BCD types, digit limits and digit arithmetic helpers.
// Pure declarations: no latency, no flow control.
// Used by bcd_digit_cell and bcd_updn_counter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MIN = 4'd0;
    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Non-BCD codes (A..F) saturate to 9 so a bad load never leaves an illegal digit.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

    // One step up within a digit, 9 rolls to 0 (the carry is handled by the chain).
    function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
        return (d >= BCD_MAX) ? BCD_MIN : bcd_digit_t'(d + 4'd1);
    endfunction

    // One step down within a digit, 0 rolls to 9 (the borrow is handled by the chain).
    function automatic bcd_digit_t bcd_dec(input bcd_digit_t d);
        return (d == BCD_MIN) ? BCD_MAX : bcd_digit_t'(d - 4'd1);
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register with load, carry/borrow-driven step and terminal flag.
// Latency: load/step visible one cycle after the edge; at_term is combinational.
// No backpressure: steps whenever step_in is high, load has priority.
module bcd_digit_cell
    import bcd_pkg::*;
#(
    parameter bcd_digit_t RST_VAL = 4'd0
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       load,
    input  bcd_digit_t load_val,
    input  logic       step_in,
    input  logic       up,
    output bcd_digit_t digit,
    output logic       at_term
);

    bcd_digit_t r_digit;

    // Digit register: reset value, then clamped load, then single step in the current direction.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_digit <= RST_VAL;
        end else if (load) begin
            r_digit <= bcd_clamp(load_val);
        end else if (step_in) begin
            r_digit <= up ? bcd_inc(r_digit) : bcd_dec(r_digit);
        end
    end

    // A digit is terminal when the next step in this direction would roll it over.
    always_comb begin
        at_term = up ? (r_digit == BCD_MAX) : (r_digit == BCD_MIN);
    end

    assign digit = r_digit;

endmodule

// File: rtl/bcd_updn_counter.sv
// N-digit BCD up/down counter with load, wrap/stop at terminal and registered terminal pulse.
// Latency: 1 cycle from enable/load to count; tc combinational, tc_pulse 1 cycle after the step.
// No backpressure; optional BCD_PRESCALE_EN macro divides steps by PRESCALE_DIV enabled cycles.
module bcd_updn_counter
    import bcd_pkg::*;
#(
    parameter int                  DIGITS       = 3,
    parameter logic [4*DIGITS-1:0] INIT_VALUE   = 12'h299,
    parameter bit                  WRAP         = 1'b0,
    parameter int                  PRESCALE_DIV = 50
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                loadN,
    input  logic [4*DIGITS-1:0] load_data,
    input  logic                enable1,
    input  logic                enable2,
    input  logic                up,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                tc_pulse
);

    logic       w_en;
    logic       w_load;
    logic       w_tick;
    logic       w_hold;
    logic       w_step;
    logic       w_upper_term;
    logic       w_next_term;
    logic       r_tc_pulse;

    bcd_digit_t w_digit   [DIGITS];
    logic       w_at_term [DIGITS];
    logic       w_step_in [DIGITS];
    logic [DIGITS-1:0] w_term_vec;

    assign w_en   = enable1 & enable2;
    assign w_load = ~loadN;

`ifdef BCD_PRESCALE_EN
    localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE_DIV - 1);

    logic [PW-1:0] r_presc;

    // Prescaler phase: advances only on enabled cycles, restarts on load and after each tick.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_presc <= '0;
        end else if (w_load) begin
            r_presc <= '0;
        end else if (w_en) begin
            r_presc <= (r_presc == PRESC_LAST) ? '0 : PW'(r_presc + 1'b1);
        end
    end

    assign w_tick = (r_presc == PRESC_LAST);
`else
    assign w_tick = 1'b1;
`endif

    // Terminal detection: whole count is terminal only when every digit is.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            w_term_vec[i] = w_at_term[i];
        end
    end

    assign tc     = &w_term_vec;
    assign w_hold = tc & ~WRAP;
    assign w_step = w_en & ~w_load & ~w_hold & w_tick;

    // Digits above the LSD must already be terminal for a step to land on terminal.
    generate
        if (DIGITS == 1) begin : g_one_digit
            assign w_upper_term = 1'b1;
        end else begin : g_multi_digit
            assign w_upper_term = &w_term_vec[DIGITS-1:1];
        end
    endgenerate

    // The step lands on terminal when the LSD is one away from its terminal value.
    always_comb begin
        w_next_term = w_upper_term & (up ? (w_digit[0] == 4'd8) : (w_digit[0] == 4'd1));
    end

    // Digit chain: each digit steps only when all lower digits are rolling over.
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            if (i == 0) begin : g_lsd
                assign w_step_in[i] = w_step;
            end else begin : g_chain
                assign w_step_in[i] = w_step_in[i-1] & w_at_term[i-1];
            end

            bcd_digit_cell #(
                .RST_VAL (INIT_VALUE[4*i +: 4])
            ) u_cell (
                .clk      (clk),
                .resetN   (resetN),
                .load     (w_load),
                .load_val (load_data[4*i +: 4]),
                .step_in  (w_step_in[i]),
                .up       (up),
                .digit    (w_digit[i]),
                .at_term  (w_at_term[i])
            );

            assign count[4*i +: 4] = w_digit[i];
        end
    endgenerate

    // Terminal pulse: one cycle after a step arrives at terminal; holding or loading never fires it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_tc_pulse <= 1'b0;
        end else if (w_load) begin
            r_tc_pulse <= 1'b0;
        end else begin
            r_tc_pulse <= w_step & w_next_term;
        end
    end

    assign tc_pulse = r_tc_pulse;

endmodule

// File: tb/tb_bcd_updn_counter.sv
// Self-checking bench: two 3-digit counters (stop and wrap) driven in parallel.
// Reference model keeps the count as a decimal integer 0..999.
// Optional prescaler modelled when BCD_PRESCALE_EN is defined.
module tb_bcd_updn_counter;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        resetN, loadN, enable1, enable2, up;
    logic [11:0] load_data;
    logic [11:0] count_s, count_w;
    logic        tc_s, tc_w, tp_s, tp_w;

    always #5 clk = ~clk;

    bcd_updn_counter #(
        .DIGITS(3), .INIT_VALUE(12'h299), .WRAP(1'b0), .PRESCALE_DIV(DIV)
    ) u_dut_stop (
        .clk(clk), .resetN(resetN), .loadN(loadN), .load_data(load_data),
        .enable1(enable1), .enable2(enable2), .up(up),
        .count(count_s), .tc(tc_s), .tc_pulse(tp_s)
    );

    bcd_updn_counter #(
        .DIGITS(3), .INIT_VALUE(12'h299), .WRAP(1'b1), .PRESCALE_DIV(DIV)
    ) u_dut_wrap (
        .clk(clk), .resetN(resetN), .loadN(loadN), .load_data(load_data),
        .enable1(enable1), .enable2(enable2), .up(up),
        .count(count_w), .tc(tc_w), .tc_pulse(tp_w)
    );

    int n_cmp = 0;
    int n_err = 0;

    int m_val   [2];
    bit m_pulse [2];
    int m_ph;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return 12'(((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic int from_load(input logic [11:0] d);
        int v = 0;
        int p = 1;
        for (int i = 0; i < 3; i++) begin
            int n = int'(d[4*i +: 4]);
            if (n > 9) n = 9;
            v += n * p;
            p *= 10;
        end
        return v;
    endfunction

    function automatic bit is_term(input int v, input bit u);
        return u ? (v == 999) : (v == 0);
    endfunction

    task automatic model_reset();
        m_val[0] = 299; m_val[1] = 299;
        m_pulse[0] = 1'b0; m_pulse[1] = 1'b0;
        m_ph = 0;
    endtask

    task automatic model_edge(input bit en1, input bit en2, input bit u, input bit ldn,
                              input logic [11:0] ld);
        bit tick = 1'b1;
`ifdef BCD_PRESCALE_EN
        if (!ldn) begin
            m_ph = 0;
        end else if (en1 && en2) begin
            tick = (m_ph == DIV - 1);
            m_ph = tick ? 0 : m_ph + 1;
        end
`endif
        for (int w = 0; w < 2; w++) begin
            if (!ldn) begin
                m_val[w]   = from_load(ld);
                m_pulse[w] = 1'b0;
            end else if (en1 && en2 && tick && !(is_term(m_val[w], u) && w == 0)) begin
                m_val[w]   = u ? (m_val[w] + 1) % 1000 : (m_val[w] + 999) % 1000;
                m_pulse[w] = is_term(m_val[w], u);
            end else begin
                m_pulse[w] = 1'b0;
            end
        end
    endtask

    task automatic check_outs(input string tag);
        chk_eq({tag, "_count_stop"}, 32'(count_s), 32'(to_bcd(m_val[0])));
        chk_eq({tag, "_count_wrap"}, 32'(count_w), 32'(to_bcd(m_val[1])));
        chk_eq({tag, "_tc_stop"},    32'(tc_s),    32'(is_term(m_val[0], up)));
        chk_eq({tag, "_tc_wrap"},    32'(tc_w),    32'(is_term(m_val[1], up)));
        chk_eq({tag, "_pulse_stop"}, 32'(tp_s),    32'(m_pulse[0]));
        chk_eq({tag, "_pulse_wrap"}, 32'(tp_w),    32'(m_pulse[1]));
    endtask

    // Called at a falling edge: drive, check combinational tc, clock once, check all outputs.
    task automatic cycle(input string tag, input bit en1, input bit en2, input bit u,
                         input bit ldn, input logic [11:0] ld);
        enable1 = en1; enable2 = en2; up = u; loadN = ldn; load_data = ld;
        #1;
        chk_eq({tag, "_tc_comb_stop"}, 32'(tc_s), 32'(is_term(m_val[0], u)));
        chk_eq({tag, "_tc_comb_wrap"}, 32'(tc_w), 32'(is_term(m_val[1], u)));
        @(posedge clk);
        model_edge(en1, en2, u, ldn, ld);
        @(negedge clk);
        check_outs(tag);
    endtask

    initial begin
        bit          r_up;
        bit          r_ldn;
        bit          r_en2;
        logic [11:0] r_ld;

        resetN = 1'b0; loadN = 1'b1; enable1 = 1'b0; enable2 = 1'b0; up = 1'b0;
        load_data = '0;
        model_reset();
        @(negedge clk);
        check_outs("reset");
        resetN = 1'b1;

        repeat (10) cycle("hold_en2", 1'b1, 1'b0, 1'b0, 1'b1, 12'h000);

        cycle("ld010", 1'b1, 1'b1, 1'b0, 1'b0, 12'h010);
        repeat (14 * DIV) cycle("down", 1'b1, 1'b1, 1'b0, 1'b1, 12'h000);

        cycle("ld998", 1'b1, 1'b1, 1'b1, 1'b0, 12'h998);
        repeat (4 * DIV) cycle("up_wrap", 1'b1, 1'b1, 1'b1, 1'b1, 12'h000);
        repeat (3 * DIV) cycle("dn_wrap", 1'b1, 1'b1, 1'b0, 1'b1, 12'h000);

        cycle("ld123", 1'b1, 1'b1, 1'b0, 1'b0, 12'h123);
        cycle("ld4a7", 1'b1, 1'b1, 1'b0, 1'b0, 12'h4A7);
        chk_eq("clamp_4a7", 32'(count_s), 32'h497);

        cycle("ld000", 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
        repeat (2 * DIV) cycle("hold0", 1'b1, 1'b1, 1'b0, 1'b1, 12'h000);
        repeat (2 * DIV) cycle("flip_up", 1'b1, 1'b1, 1'b1, 1'b1, 12'h000);

        cycle("ld005", 1'b1, 1'b1, 1'b0, 1'b0, 12'h005);
        repeat (3) cycle("presc_a", 1'b1, 1'b1, 1'b0, 1'b1, 12'h000);
        repeat (3) cycle("presc_pause", 1'b1, 1'b0, 1'b0, 1'b1, 12'h000);
        repeat (2) cycle("presc_b", 1'b1, 1'b1, 1'b0, 1'b1, 12'h000);
        cycle("presc_ld", 1'b1, 1'b1, 1'b0, 1'b0, 12'h005);
        repeat (2 * DIV) cycle("presc_c", 1'b1, 1'b1, 1'b0, 1'b1, 12'h000);

        r_up = 1'b0;
        repeat (600) begin
            if ($urandom_range(0, 7) == 0) r_up = ~r_up;
            r_ldn = ($urandom_range(0, 15) != 0);
            r_en2 = ($urandom_range(0, 5) != 0);
            case ($urandom_range(0, 3))
                0:       r_ld = 12'h998;
                1:       r_ld = 12'h001;
                2:       r_ld = 12'($urandom);
                default: r_ld = 12'h000;
            endcase
            cycle("rand", ($urandom_range(0, 7) != 0), r_en2, r_up, r_ldn, r_ld);
        end

        // Asynchronous reset in the middle of a cycle with counting enabled.
        enable1 = 1'b1; enable2 = 1'b1; loadN = 1'b1; up = 1'b0;
        #2;
        resetN = 1'b0;
        #1;
        model_reset();
        check_outs("async_rst");
        @(negedge clk);
        resetN = 1'b1;
        repeat (2 * DIV) cycle("post_rst", 1'b1, 1'b1, 1'b0, 1'b1, 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
